// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator request scheduler.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package elev_pkg;

    localparam int DEF_NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_DOOR_OPEN,
        ST_ESTOP
    } elev_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Floor vectors are zero-extended to 32 bits. For one-hot cur, cur-1 marks every floor below it.
    function automatic logic any_above(input logic [31:0] pend, input logic [31:0] cur);
        return |(pend & ~(cur | (cur - 32'd1)));
    endfunction

    function automatic logic any_below(input logic [31:0] pend, input logic [31:0] cur);
        return |(pend & (cur - 32'd1));
    endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Tick-enabled counter with clear, freeze and a terminal-count done strobe.
// Latency: done is combinational on the TERM-th tick; the count wraps to 0 on that same edge.
// Backpressure: none; clr beats frz, and frz beats tick.
module elev_tick_timer #(
    parameter int W    = 5,
    parameter int TERM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    input  logic frz,
    output logic done
);

    localparam logic [W-1:0] LAST = W'(TERM - 1);

    logic [W-1:0] count;

    // Compare with >= so that a corrupted count can never run on past the terminal value.
    assign done = tick && !clr && !frz && (count >= LAST);

    // Count ticks. Clear on request or at the terminal count, and hold while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || done) begin
            count <= '0;
        end else if (tick && !frz) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN-order elevator scheduler: latches floor calls, steps the one-hot car position, runs the door dwell.
// Latency: a call is pending on its edge and motion starts on the next; the door opens one clk after arrival.
// Backpressure: none. Calls are OR-latched every edge, and emergency_stop freezes motion. Optional feature: ELEV_SCHED_IDLE_HOME_EN.
module elevator_request_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int MOVE_TICKS = 8,
    parameter int DOOR_TICKS = 4,
    parameter int HOME_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  emergency_stop,
    output logic [NUM_FLOORS-1:0] cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  busy
);

    localparam int TW = $clog2(max3(MOVE_TICKS, DOOR_TICKS, HOME_TICKS) + 1);

    elev_state_t           state;
    logic                  dir;        // 1 = up
    logic                  arrived;    // the car shifted floor on the previous edge
    logic                  pend_up, pend_dn, here, ahead, behind, go_dir;
    logic                  deciding, enter_door;
    logic                  move_done, door_done, move_clr, door_clr, tmr_frz;
    logic [NUM_FLOORS-1:0] clear_mask, home_mask, pending_nxt, step_floor;

    assign pend_up  = any_above(32'(pending), 32'(cur_floor));
    assign pend_dn  = any_below(32'(pending), 32'(cur_floor));
    assign here     = |(pending & cur_floor);
    assign ahead    = dir ? pend_up : pend_dn;
    assign behind   = dir ? pend_dn : pend_up;
    assign go_dir   = ahead ? dir : ~dir;

    // The SCAN decision runs every edge in IDLE and on the edge after each floor arrival.
    assign deciding   = !emergency_stop && ((state == ST_IDLE) || (state == ST_MOVING && arrived));
    assign enter_door = deciding && here;
    assign clear_mask = (state == ST_DOOR_OPEN || enter_door) ? cur_floor : '0;

    assign step_floor = dir ? {cur_floor[NUM_FLOORS-2:0], 1'b0} : {1'b0, cur_floor[NUM_FLOORS-1:1]};

    // During an emergency stop the timers hold. Releasing the stop throws away a partial floor move.
    assign tmr_frz  = emergency_stop || (state == ST_ESTOP);
    assign move_clr = (state == ST_MOVING) ? arrived : !(state == ST_ESTOP && emergency_stop);
    assign door_clr = (state == ST_DOOR_OPEN) ? |(call_req & cur_floor) : (state != ST_ESTOP);

    elev_tick_timer #(.W(TW), .TERM(MOVE_TICKS)) u_move_tmr (
        .clk (clk), .rst (rst), .tick (tick), .clr (move_clr), .frz (tmr_frz), .done (move_done)
    );

    elev_tick_timer #(.W(TW), .TERM(DOOR_TICKS)) u_door_tmr (
        .clk (clk), .rst (rst), .tick (tick), .clr (door_clr), .frz (tmr_frz), .done (door_done)
    );

`ifdef ELEV_SCHED_IDLE_HOME_EN
    logic home_clr, home_done;

    // Count only while the car is parked away from floor 0 with nothing to do.
    assign home_clr = (state != ST_IDLE) || (|call_req) || emergency_stop || (|pending) || cur_floor[0];

    elev_tick_timer #(.W(TW), .TERM(HOME_TICKS)) u_home_tmr (
        .clk (clk), .rst (rst), .tick (tick), .clr (home_clr), .frz (1'b0), .done (home_done)
    );

    assign home_mask = NUM_FLOORS'(home_done);
`else
    assign home_mask = '0;
`endif

    assign pending_nxt = (pending | call_req | home_mask) & ~clear_mask;

    // State machine with registered status outputs. Emergency stop takes priority, but calls keep latching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_floor   <= NUM_FLOORS'(1);
            pending     <= '0;
            dir         <= 1'b1;
            arrived     <= 1'b0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pending <= pending_nxt;
            arrived <= 1'b0;
            if (emergency_stop) begin
                state       <= ST_ESTOP;
                moving_up   <= 1'b0;
                moving_down <= 1'b0;
                busy        <= 1'b1;
            end else if (deciding) begin
                if (here) begin
                    state       <= ST_DOOR_OPEN;
                    door_open   <= 1'b1;
                    busy        <= 1'b1;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                end else if (ahead || behind) begin
                    state       <= ST_MOVING;
                    dir         <= go_dir;
                    moving_up   <= go_dir;
                    moving_down <= ~go_dir;
                    busy        <= 1'b1;
                end else begin
                    state       <= ST_IDLE;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    busy        <= 1'b0;
                end
            end else begin
                case (state)
                    ST_MOVING: begin
                        if (move_done) begin
                            cur_floor <= step_floor;
                            arrived   <= 1'b1;
                        end
                    end
                    ST_DOOR_OPEN: begin
                        if (door_done) begin
                            state     <= ST_IDLE;
                            door_open <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    ST_ESTOP: begin
                        state     <= ST_IDLE;
                        door_open <= 1'b0;
                        busy      <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The direction choice only moves toward pending floors, so a shift off either end means the decision logic is broken.
    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        (state == ST_MOVING && move_done) |-> !(dir ? cur_floor[NUM_FLOORS-1] : cur_floor[0]));

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler against an integer-floor behavioural model.
// Latency: the expected outputs for each edge are queued at stimulus time and compared 2 time units after that edge.
// Backpressure: not applicable.
module tb_elevator_request_scheduler;

    localparam int MOVE_T  = 8;
    localparam int DOOR_T  = 4;
    localparam int HOME_T  = 16;
    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;
    localparam int PH_STOP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       emergency_stop = 1'b0;
    logic [3:0] call_req = 4'b0;
    logic [3:0] cur_floor, pending;
    logic       moving_up, moving_down, door_open, busy;

    elevator_request_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .call_req       (call_req),
        .emergency_stop (emergency_stop),
        .cur_floor      (cur_floor),
        .pending        (pending),
        .moving_up      (moving_up),
        .moving_down    (moving_down),
        .door_open      (door_open),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fl;
        logic [3:0] pd;
        logic       up, dn, dr, bz;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model state: the floor is kept as an integer and the phase as a plain int.
    int         m_floor, m_phase, m_mcnt, m_dcnt, m_hcnt;
    logic [3:0] m_pend;
    bit         m_dir, m_arr, m_up, m_dn, m_door, m_busy;
    bit         tick_rand = 0;
    bit         last_tk = 0;
    int         cyc_n = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, want);
        end
    endtask

    function automatic logic [3:0] onehot(input int f);
        logic [3:0] v;
        v = 4'd1;
        return v << f;
    endfunction

    function automatic bit pend_toward(input logic [3:0] p, input int floor, input bit up);
        for (int f = 0; f < 4; f++)
            if (p[f] && (up ? (f > floor) : (f < floor))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_phase = PH_IDLE; m_mcnt = 0; m_dcnt = 0; m_hcnt = 0;
        m_pend = 4'b0; m_dir = 1'b1; m_arr = 1'b0;
        m_up = 1'b0; m_dn = 1'b0; m_door = 1'b0; m_busy = 1'b0;
    endtask

    // Apply one clk edge of behaviour to the model.
    task automatic model_step(input logic [3:0] call, input bit tk, input bit es);
        logic [3:0] p_old, p_new;
        bit         was_arr, clr_here;
        p_old    = m_pend;
        p_new    = p_old | call;
        was_arr  = m_arr;
        m_arr    = 1'b0;
        clr_here = (m_phase == PH_DOOR);
`ifdef ELEV_SCHED_IDLE_HOME_EN
        if (m_phase == PH_IDLE && p_old == 4'b0 && m_floor != 0 && call == 4'b0 && !es) begin
            if (tk) begin
                m_hcnt++;
                if (m_hcnt == HOME_T) begin
                    p_new[0] = 1'b1;
                    m_hcnt   = 0;
                end
            end
        end else begin
            m_hcnt = 0;
        end
`endif
        if (es) begin
            m_phase = PH_STOP; m_up = 1'b0; m_dn = 1'b0; m_busy = 1'b1;
        end else if (m_phase == PH_IDLE || (m_phase == PH_MOVE && was_arr)) begin
            if (p_old[m_floor]) begin
                m_phase = PH_DOOR; m_door = 1'b1; m_busy = 1'b1;
                m_up = 1'b0; m_dn = 1'b0; m_dcnt = 0; clr_here = 1'b1;
            end else if (pend_toward(p_old, m_floor, m_dir) || pend_toward(p_old, m_floor, !m_dir)) begin
                if (!pend_toward(p_old, m_floor, m_dir)) m_dir = !m_dir;
                m_phase = PH_MOVE; m_busy = 1'b1; m_up = m_dir; m_dn = !m_dir; m_mcnt = 0;
            end else begin
                m_phase = PH_IDLE; m_busy = 1'b0; m_up = 1'b0; m_dn = 1'b0;
            end
        end else if (m_phase == PH_MOVE) begin
            if (tk) begin
                m_mcnt++;
                if (m_mcnt == MOVE_T) begin
                    m_floor = m_floor + (m_dir ? 1 : -1);
                    m_mcnt  = 0;
                    m_arr   = 1'b1;
                end
            end
        end else if (m_phase == PH_DOOR) begin
            if (call[m_floor]) begin
                m_dcnt = 0;
            end else if (tk) begin
                m_dcnt++;
                if (m_dcnt == DOOR_T) begin
                    m_phase = PH_IDLE; m_door = 1'b0; m_busy = 1'b0;
                end
            end
        end else begin
            m_phase = PH_IDLE; m_door = 1'b0; m_busy = 1'b0;
        end
        if (clr_here) p_new[m_floor] = 1'b0;
        m_pend = p_new;
    endtask

    // Drive one cycle of stimulus on the falling edge, then queue what the DUT must show after the next rising edge.
    task automatic do_cycle(input logic [3:0] call, input bit es);
        bit tk;
        @(negedge clk);
        rst = 1'b0;
        cyc_n++;
        if (tick_rand) tk = !last_tk && ($urandom_range(0, 1) == 1);
        else           tk = (cyc_n % 2 == 0);
        last_tk        = tk;
        tick           = tk;
        call_req       = call;
        emergency_stop = es;
        model_step(call, tk, es);
        sb_q.push_back('{onehot(m_floor), m_pend, m_up, m_dn, m_door, m_busy});
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle(4'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cur_floor"}, cur_floor, 4'b0001);
        chk({tag, "_pending"},   pending,   4'b0000);
        chk({tag, "_moving_up"}, {3'b0, moving_up},   4'b0);
        chk({tag, "_moving_dn"}, {3'b0, moving_down}, 4'b0);
        chk({tag, "_door_open"}, {3'b0, door_open},   4'b0);
        chk({tag, "_busy"},      {3'b0, busy},        4'b0);
    endtask

    // Raise reset between clock edges and check the outputs before any rising edge arrives.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
    endtask

    // Monitor: pop one expectation per scored edge and compare every output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("cur_floor",   cur_floor,           e.fl);
                chk("pending",     pending,             e.pd);
                chk("moving_up",   {3'b0, moving_up},   {3'b0, e.up});
                chk("moving_down", {3'b0, moving_down}, {3'b0, e.dn});
                chk("door_open",   {3'b0, door_open},   {3'b0, e.dr});
                chk("busy",        {3'b0, busy},        {3'b0, e.bz});
            end
        end
    end

    initial begin
        int es_left;
        bit es;
        logic [3:0] c;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Single call to the top floor: walk up, dwell, then go idle.
        do_cycle(4'b1000, 1'b0);
        run(80);

        // Start moving down, then hit reset mid-move.
        do_cycle(4'b0001, 1'b0);
        run(3);
        do_cycle(4'b1000, 1'b0);
        run(10);
        async_reset_check();

        // SCAN: travelling up with a call at the top, a call for floor 0 arrives mid-trip.
        do_cycle(4'b1000, 1'b0);
        run(40);
        do_cycle(4'b0001, 1'b0);
        run(160);

        // Call at the current floor while idle.
        do_cycle(4'b0001, 1'b0);
        run(20);

        // Emergency stop mid-floor, with a call latched while stopped.
        do_cycle(4'b1000, 1'b0);
        run(11);
        repeat (20) do_cycle(4'b0, 1'b1);
        do_cycle(4'b0010, 1'b1);
        repeat (19) do_cycle(4'b0, 1'b1);
        run(130);

        // Park at the top floor long enough for the home timer to matter.
        run(140);

        // Randomised traffic with irregular ticks and short emergency stops.
        tick_rand = 1'b1;
        es_left   = 0;
        for (int i = 0; i < 4000; i++) begin
            c = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            if (es_left > 0) begin
                es = 1'b1;
                es_left--;
            end else if ($urandom_range(0, 199) == 0) begin
                es      = 1'b1;
                es_left = $urandom_range(1, 30);
            end else begin
                es = 1'b0;
            end
            do_cycle(c, es);
        end
        run(200);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
